// File: rtl/fetch_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_buffer_if
//   Instruction-bus bundle between the fetch buffer (master) and the
//   instruction memory / bus fabric (slave).
//
//   ibus_req_o    : read request from the fetch buffer
//   ibus_addr_o   : read address (the current fetch PC)
//   ibus_gnt_i    : request accepted this cycle
//   ibus_rvalid_i : read data valid, responses return in request order
//   ibus_rdata_i  : read data
// -----------------------------------------------------------------------------
interface fetch_buffer_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_gnt_i,
    input  ibus_rvalid_i,
    input  ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_gnt_i,
    output ibus_rvalid_i,
    output ibus_rdata_i
  );
endinterface

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   In-order instruction fetch queue between the PC stage and decode. Every
//   granted bus read allocates a slot tagged with its PC and prediction bit;
//   the slot is filled when the in-order read data returns and is handed to
//   decode over a valid/ready handshake. A redirect (flush_i) empties the
//   queue and remembers how many bus responses are still owed so that the
//   wrong-path data can be discarded when it arrives.
//
//   Parameters
//     DEPTH      queue entries (power of two, >= 2), also the outstanding cap
//     RESET_NOP  instruction presented while nothing is valid
//
//   Ports
//     clk, rst           core clock, synchronous active-high reset
//     pc_i               fetch address from the PC stage
//     predict_to_jump_i  PC stage predicted taken for pc_i
//     flush_i            redirect, discards all queued / in-flight fetches
//     hold_pc_o          PC must not advance (no fetch granted this cycle)
//     ibus               instruction bus (master side)
//     inst_valid_o       head instruction valid toward decode
//     inst_ready_i       decode accepts the head
//     inst_o             head instruction
//     inst_addr_o        head PC
//     inst_pred_o        head prediction bit
// -----------------------------------------------------------------------------
module fetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_i,
  input  logic                  predict_to_jump_i,
  input  logic                  flush_i,
  output logic                  hold_pc_o,
  fetch_buffer_if.master        ibus,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [31:0]           inst_o,
  output logic [31:0]           inst_addr_o,
  output logic                  inst_pred_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full (difference == DEPTH) and
  // empty (difference == 0) are distinguishable without a separate counter.
  typedef logic [AW:0] ptr_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

  ptr_t r_alloc_ptr;
  ptr_t r_fill_ptr;
  ptr_t r_rd_ptr;
  ptr_t r_drop_cnt;   // responses still owed for flushed requests

  logic [31:0]      r_addr [DEPTH];
  logic [31:0]      r_inst [DEPTH];
  logic [DEPTH-1:0] r_pred;
  logic [DEPTH-1:0] r_filled;

  ptr_t          w_used;
  ptr_t          w_unfilled;
  ptr_t          w_owed;
  ptr_t          w_flush_drop;
  logic [AW-1:0] w_alloc_idx;
  logic [AW-1:0] w_fill_idx;
  logic [AW-1:0] w_head_idx;
  logic          w_req;
  logic          w_grant;
  logic          w_fill;
  logic          w_drop;
  logic          w_valid;
  logic          w_pop;

  assign w_used      = r_alloc_ptr - r_rd_ptr;
  assign w_unfilled  = r_alloc_ptr - r_fill_ptr;
  assign w_alloc_idx = r_alloc_ptr[AW-1:0];
  assign w_fill_idx  = r_fill_ptr[AW-1:0];
  assign w_head_idx  = r_rd_ptr[AW-1:0];

  // used + drop_cnt never exceeds DEPTH, so the sum fits in a pointer.
  assign w_req   = !rst && !flush_i && ((w_used + r_drop_cnt) < PTR_DEPTH);
  assign w_grant = w_req && ibus.ibus_gnt_i;

  // A response pays off a flushed request first; only when nothing is owed
  // does it fill the oldest unfilled slot. Data with nothing pending at all
  // is a protocol error and is ignored.
  assign w_drop = !flush_i && ibus.ibus_rvalid_i && (r_drop_cnt != '0);
  assign w_fill = !flush_i && ibus.ibus_rvalid_i && (r_drop_cnt == '0)
                  && (w_unfilled != '0);

  // On a redirect every unfilled slot becomes an owed response; the response
  // arriving in the flush cycle itself is consumed here.
  assign w_owed       = r_drop_cnt + w_unfilled;
  assign w_flush_drop = (ibus.ibus_rvalid_i && (w_owed != '0)) ? (w_owed - PTR_ONE)
                                                               : w_owed;

  assign w_valid = !flush_i && (w_used != '0) && r_filled[w_head_idx];
  assign w_pop   = w_valid && inst_ready_i;

  assign ibus.ibus_req_o  = w_req;
  assign ibus.ibus_addr_o = pc_i;
  assign hold_pc_o        = !w_grant;

  assign inst_valid_o = w_valid;
  assign inst_o       = w_valid ? r_inst[w_head_idx] : RESET_NOP;
  assign inst_addr_o  = w_valid ? r_addr[w_head_idx] : 32'h0;
  assign inst_pred_o  = w_valid && r_pred[w_head_idx];

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the grant/fill/pop updates below rely on that.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_rd_ptr    <= '0;
      r_drop_cnt  <= '0;
      r_filled    <= '0;
    end else if (flush_i) begin
      // No grant (req is low) and no pop (valid is low) in a flush cycle.
      r_fill_ptr <= r_alloc_ptr;
      r_rd_ptr   <= r_alloc_ptr;
      r_drop_cnt <= w_flush_drop;
    end else begin
      // Alloc and fill never hit the same slot: they coincide only when the
      // queue is fully unfilled, and then req is low.
      if (w_grant) begin
        r_alloc_ptr           <= r_alloc_ptr + PTR_ONE;
        r_filled[w_alloc_idx] <= 1'b0;
      end
      if (w_fill) begin
        r_fill_ptr           <= r_fill_ptr + PTR_ONE;
        r_filled[w_fill_idx] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - PTR_ONE;
      end
    end
  end

  // NOTE: the payload RAM has no reset; a slot is only read after its filled
  // bit is set, and those bits are cleared on allocation and on reset.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_addr[w_alloc_idx] <= pc_i;
      r_pred[w_alloc_idx] <= predict_to_jump_i;
    end
    if (w_fill) begin
      r_inst[w_fill_idx] <= ibus.ibus_rdata_i;
    end
  end

`ifdef __DEBUG__
  // Sticky flag: read data arrived with no request outstanding.
  logic r_proto_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (ibus.ibus_rvalid_i && (r_drop_cnt == '0) && (w_unfilled == '0)) begin
      r_proto_err <= 1'b1;
    end
  end
`endif

endmodule
